// File: rtl/ex_wb_stage.sv
// rtl/ex_wb_stage.sv - execute/retire stage: writeback record, branch resolve, accelerator handshake
module ex_wb_stage #(
    parameter int DATA_W      = 19,
    parameter int REG_AW      = 4,
    parameter int ACC_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic              in_div0,
    input  logic              in_ovf_add,
    input  logic              in_ovf_sub,
    input  logic              in_cmp_eq,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_target,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wr_en,
    output logic [3:0]        out_flags,

    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,

    output logic              acc_start,
    output logic [1:0]        acc_sel,
    input  logic              acc_done,
    input  logic [DATA_W-1:0] acc_data,

    output logic              illegal_op,
    output logic              acc_timeout,
    input  logic              clr_status
);

    // Wide enough for the largest supported timeout (1023).
    localparam int               CNT_W    = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_ACC_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        C_ALU     = 2'd0,
        C_BRANCH  = 2'd1,
        C_ACC     = 2'd2,
        C_ILLEGAL = 2'd3
    } op_class_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [REG_AW-1:0] acc_rd;

    op_class_t         in_class;
    logic              accept;

    logic              rec_load;
    logic [DATA_W-1:0] rec_result;
    logic [REG_AW-1:0] rec_rd;
    logic              rec_wr_en;
    logic [3:0]        rec_flags;

    logic              br_load;
    logic              br_pulse;
    logic              acc_go;
    logic              set_illegal;
    logic              set_timeout;

    // New records are only taken in IDLE and only when the output slot is free or draining.
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Sort the incoming opcode into the four handling classes.
    always_comb begin
        in_class = C_ILLEGAL;
        if (in_opcode <= 5'd9) begin
            in_class = C_ALU;
        end else if (in_opcode <= 5'd12) begin
            in_class = C_BRANCH;
        end else if ((in_opcode >= 5'd24) && (in_opcode <= 5'd26)) begin
            in_class = C_ACC;
        end
    end

    // Next-state logic and the record/branch/accelerator load decisions.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        rec_load    = 1'b0;
        rec_result  = '0;
        rec_rd      = in_rd;
        rec_wr_en   = 1'b0;
        rec_flags   = 4'b0000;
        br_load     = 1'b0;
        br_pulse    = 1'b0;
        acc_go      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (in_class)
                        C_ALU: begin
                            rec_load   = 1'b1;
                            rec_result = in_result;
                            rec_wr_en  = 1'b1;
                            rec_flags  = {in_ovf_sub, in_ovf_add, in_div0, in_zero};
                        end
                        C_BRANCH: begin
                            // Branches retire without writing; the redirect is a separate pulse.
                            rec_load   = 1'b1;
                            rec_result = in_result;
                            rec_flags  = {in_ovf_sub, in_ovf_add, in_div0, in_zero};
                            br_load    = 1'b1;
                            if (in_opcode == 5'd10) begin
                                br_pulse = 1'b1;
                            end else if (in_opcode == 5'd11) begin
                                br_pulse = in_cmp_eq;
                            end else begin
                                br_pulse = !in_cmp_eq;
                            end
                        end
                        C_ACC: begin
                            acc_go     = 1'b1;
                            cnt_next   = '0;
                            state_next = S_ACC_WAIT;
                        end
                        default: begin
                            rec_load    = 1'b1;
                            set_illegal = 1'b1;
                        end
                    endcase
                end
            end

            S_ACC_WAIT: begin
                rec_rd = acc_rd;
                if (acc_done) begin
                    // Completion beats a coincident timeout.
                    rec_load   = 1'b1;
                    rec_result = acc_data;
                    rec_wr_en  = 1'b1;
                    rec_flags  = {3'b000, (acc_data == '0)};
                    state_next = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    rec_load    = 1'b1;
                    rec_result  = '1;
                    set_timeout = 1'b1;
                    state_next  = S_IDLE;
                end else begin
                    cnt_next = cnt + 10'd1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Accelerator launch: single start pulse, select and destination captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_start <= 1'b0;
            acc_sel   <= 2'd0;
            acc_rd    <= '0;
        end else begin
            acc_start <= acc_go;
            if (acc_go) begin
                acc_sel <= 2'(in_opcode - 5'd24);
                acc_rd  <= in_rd;
            end
        end
    end

    // Retire record; fields only change on a load, so a stalled record stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_wr_en  <= 1'b0;
            out_flags  <= 4'b0000;
        end else begin
            if (rec_load) begin
                out_valid  <= 1'b1;
                out_result <= rec_result;
                out_rd     <= rec_rd;
                out_wr_en  <= rec_wr_en;
                out_flags  <= rec_flags;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

    // Fetch redirect: one-cycle pulse, independent of downstream backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            branch_taken <= br_pulse;
            if (br_load) begin
                branch_target <= in_target;
            end
        end
    end

    // Sticky status; a setting event in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op  <= 1'b0;
            acc_timeout <= 1'b0;
        end else begin
            if (set_illegal) begin
                illegal_op <= 1'b1;
            end else if (clr_status) begin
                illegal_op <= 1'b0;
            end
            if (set_timeout) begin
                acc_timeout <= 1'b1;
            end else if (clr_status) begin
                acc_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute-retire stage directly downstream of the ALU. Registers the ALU result and flags into a writeback record.
- Resolves jmp/beq/bne, then drives the FFT/crypto accelerator handshake for opcodes 24–26 and stalls upstream until the accelerator completes or times out.
- Feeds the register-file write port and the fetch redirect.

Parameters:
- DATA_W, 19, datapath width; matches the ALU result width.
- REG_AW, 4, destination register address width.
- ACC_TIMEOUT, 255, maximum accelerator wait cycles before abort; valid range 1..1023.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream record valid.
- in_ready  out  1  stage can accept a record.
- in_opcode  in  5  opcode as presented to the ALU.
- in_result  in  DATA_W  ALU result.
- in_zero  in  1  ALU zero flag.
- in_div0  in  1  ALU divide-by-zero flag.
- in_ovf_add  in  1  ALU add overflow.
- in_ovf_sub  in  1  ALU subtract overflow.
- in_cmp_eq  in  1  operand equality from decode, used by beq/bne.
- in_rd  in  REG_AW  destination register.
- in_target  in  DATA_W  branch/jump target.
- out_valid  out  1  retire record valid.
- out_ready  in  1  consumer accepts the record.
- out_result  out  DATA_W  writeback data.
- out_rd  out  REG_AW  writeback register.
- out_wr_en  out  1  record writes the register file.
- out_flags  out  4  {ovf_sub, ovf_add, div0, zero} of the record.
- branch_taken  out  1  one-cycle redirect pulse.
- branch_target  out  DATA_W  redirect address; valid while branch_taken=1.
- acc_start  out  1  one-cycle accelerator start pulse.
- acc_sel  out  2  accelerator select: 0=fft, 1=encrypt, 2=decrypt.
- acc_done  in  1  accelerator completion pulse.
- acc_data  in  DATA_W  accelerator result; valid with acc_done.
- illegal_op  out  1  sticky: an unsupported opcode was retired.
- acc_timeout  out  1  sticky: an accelerator wait expired.
- clr_status  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset state:
  - FSM in IDLE.
  - All outputs 0.
  - Timeout counter 0.
  - Reset asserted mid-ACC_WAIT aborts the operation: no acc_start re-pulse after release, pending acc_done ignored.
- States:
  - IDLE: accept or hold.
  - ACC_WAIT: waiting on the accelerator.
- Handshakes:
  - in_ready = (state==IDLE) && (!out_valid || out_ready); combinational.
  - Accept = in_valid && in_ready.
  - While out_valid=1 && out_ready=0, every out_* signal is held stable.
  - out_valid clears on out_ready unless a new record loads in the same cycle (back-to-back, full throughput).
- Opcodes 0–9 (arithmetic/logic):
  - On accept: out_result=in_result, out_rd=in_rd, out_wr_en=1, out_flags from the in_* flags.
  - out_valid=1 next cycle; latency 1.
- Opcode 10 (jmp):
  - On accept: branch_taken=1 for exactly the next cycle, branch_target=in_target.
  - Retire record issued with out_wr_en=0.
- Opcode 11 (beq) / 12 (bne):
  - Same as jmp, but branch_taken=in_cmp_eq for beq and =!in_cmp_eq for bne.
  - in_zero is not used for branches.
  - The branch pulse is independent of out_ready.
- Opcodes 24/25/26 (accelerator):
  - On accept: go to ACC_WAIT; acc_sel = opcode-24.
  - acc_start=1 for exactly the first ACC_WAIT cycle; counter loads 0.
  - acc_done is sampled every ACC_WAIT cycle, including the acc_start cycle.
  - On acc_done: out_result=acc_data, out_wr_en=1, out_flags={0,0,0,acc_data==0}, out_valid=1, return to IDLE.
  - If the counter reaches ACC_TIMEOUT without acc_done: out_result=19'h7FFFF, out_wr_en=0, acc_timeout set, out_valid=1, return to IDLE.
  - Counter and acc_done in the same cycle: acc_done wins.
  - acc_done seen in IDLE is ignored.
  - acc_sel holds its value until the next accelerator accept.
- Other opcodes (13–23, 27–31):
  - Retire with out_wr_en=0, out_result=0, flags 0; illegal_op set.
- Sticky flags:
  - illegal_op and acc_timeout hold until clr_status=1.
  - If clr_status=1 in the same cycle as a setting event, set wins.

Test Plan:
1. add: opcode 0, result 19'h00005, rd 3, out_ready=1 → out_valid next cycle, out_wr_en=1, out_result=5, out_rd=3, out_flags=4'b0000; three back-to-back records retire on consecutive cycles.
2. Backpressure: out_ready=0 for 4 cycles with a record held → in_ready=0, out_* unchanged; out_ready=1 → record retires, next record accepted in the same cycle.
3. Branches: beq with in_cmp_eq=1, target 19'h00040 → branch_taken one cycle, branch_target=0x40, out_wr_en=0; bne with in_cmp_eq=1 → branch_taken stays 0.
4. FFT: opcode 24 → acc_start single pulse, acc_sel=0, in_ready=0; acc_done with acc_data=19'h1234 five cycles later → out_result=0x1234, out_wr_en=1, in_ready returns.
5. Accelerator timeout: ACC_TIMEOUT=8, opcode 25, no acc_done → after 8 wait cycles out_result=19'h7FFFF, out_wr_en=0, acc_timeout=1; a late acc_done is ignored; clr_status clears acc_timeout.
6. Reset and illegal opcode: rst_n low in ACC_WAIT cycle 3 → all outputs 0, IDLE, no acc_start after release; then opcode 15 → out_wr_en=0, illegal_op=1.
